// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, reset PC and fetch state encodings for the fetch stage.
package if_fetch_unit_pkg;
  localparam int INST_BUS = 32;
  localparam int REG_BUS = 64;
  localparam logic [63:0] PC_START = 64'h8000_0000;
  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;
endpackage

// File: rtl/if_fetch_unit_inst_select.sv
// if_inst_select: picks the 32-bit instruction word out of a 64-bit read beat.
module if_inst_select
  import if_fetch_unit_pkg::*;
(
  input  logic [REG_BUS-1:0]  data_i,
  input  logic                hi_i,
  output logic [INST_BUS-1:0] inst_o
);
  assign inst_o = hi_i ? data_i[REG_BUS-1:INST_BUS] : data_i[INST_BUS-1:0];
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC holder issuing one aligned 64-bit read at a time and handing
// the selected instruction to decode over valid/ready, with exe_stage redirects.
module if_fetch_unit #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] PC_START = if_fetch_unit_pkg::PC_START
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [63:0]       resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [63:0]       fetch_cnt
);
  import if_fetch_unit_pkg::*;
  if_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d, inst_pc_q, inst_pc_d, rpc;
  logic drop_q, drop_d, inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d, sel;
  logic [63:0] cnt_q, cnt_d;
  if_inst_select u_sel (.data_i(resp_data), .hi_i(pc_q[2]), .inst_o(sel));
  assign rpc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign req_valid = state_q == IF_REQ;
  assign req_addr = {pc_q[ADDR_W-1:3], 3'b000};
  assign inst_valid = inst_valid_q;
  assign inst = inst_q;
  assign inst_pc = inst_pc_q;
  assign fetch_cnt = cnt_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    tgt_d = tgt_q;
    drop_d = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d = cnt_q;
    if (state_q == IF_REQ) begin
      // req_addr must hold while the request is pending, so park the target in tgt_q
      if (redirect_valid) begin
        tgt_d = rpc;
        drop_d = 1'b1;
      end
      if (req_ready) begin
        state_d = IF_WAIT;
        pc_d = redirect_valid ? rpc : drop_q ? tgt_q : pc_q;
      end
    end else if (state_q == IF_WAIT) begin
      if (resp_valid) begin
        state_d = (redirect_valid || drop_q) ? IF_REQ : IF_HOLD;
        drop_d = 1'b0;
        pc_d = redirect_valid ? rpc : pc_q;
        if (!redirect_valid && !drop_q) begin
          inst_d = sel;
          inst_pc_d = pc_q;
          inst_valid_d = 1'b1;
        end
      end else if (redirect_valid) begin
        pc_d = rpc;
        drop_d = 1'b1;
      end
    end else if (state_q == IF_HOLD) begin
      cnt_d = inst_ready ? cnt_q + 64'd1 : cnt_q;
      if (redirect_valid || inst_ready) begin
        inst_valid_d = 1'b0;
        state_d = IF_REQ;
        pc_d = redirect_valid ? rpc : pc_q + ADDR_W'(4);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IF_REQ;
      pc_q <= PC_START;
      tgt_q <= '0;
      drop_q <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q <= '0;
      inst_pc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      tgt_q <= tgt_d;
      drop_q <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch sequencing, stalls, redirects and reset.
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic rst, redirect_valid, req_valid, req_ready, resp_valid, inst_valid, inst_ready;
  logic [63:0] redirect_pc, req_addr, resp_data, inst_pc, fetch_cnt;
  logic [31:0] inst;
  int checks = 0;
  int errors = 0;
  if_fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .fetch_cnt(fetch_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; inst_ready = 1'b0;
    tick; tick;
    chk("rst_req_valid", 64'(req_valid), 64'd1);
    chk("rst_req_addr", req_addr, 64'h8000_0000);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_cnt", fetch_cnt, 64'd0);
    rst = 1'b0; req_ready = 1'b1; inst_ready = 1'b1;
    tick;
    resp_valid = 1'b1; resp_data = 64'h1111_2222_3333_4444;
    tick;
    chk("t1_iv0", 64'(inst_valid), 64'd1);
    chk("t1_inst0", 64'(inst), 64'h3333_4444);
    chk("t1_pc0", inst_pc, 64'h8000_0000);
    resp_valid = 1'b0;
    tick;
    chk("t1_addr1", req_addr, 64'h8000_0000);
    chk("t1_req_valid1", 64'(req_valid), 64'd1);
    chk("t1_cnt1", fetch_cnt, 64'd1);
    tick;
    resp_valid = 1'b1; resp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick;
    chk("t1_inst1", 64'(inst), 64'hAAAA_BBBB);
    chk("t1_pc1", inst_pc, 64'h8000_0004);
    resp_valid = 1'b0;
    tick;
    chk("t1_cnt2", fetch_cnt, 64'd2);
    chk("t1_addr2", req_addr, 64'h8000_0008);
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_req_valid", 64'(req_valid), 64'd1);
      chk("stall_addr", req_addr, 64'h8000_0008);
      chk("stall_iv", 64'(inst_valid), 64'd0);
    end
    req_ready = 1'b1;
    tick;
    resp_valid = 1'b1; resp_data = 64'h0123_4567_89AB_CDEF;
    tick;
    chk("t5_inst", 64'(inst), 64'h89AB_CDEF);
    chk("t5_pc", inst_pc, 64'h8000_0008);
    resp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0040;
    tick;
    redirect_valid = 1'b0;
    chk("t5_iv_drop", 64'(inst_valid), 64'd0);
    chk("t5_cnt", fetch_cnt, 64'd3);
    chk("t5_addr", req_addr, 64'h8000_0040);
    tick;
    resp_valid = 1'b1; resp_data = 64'hDEAD_BEEF_CAFE_F00D;
    tick;
    chk("t5_redir_pc", inst_pc, 64'h8000_0040);
    chk("t5_redir_inst", 64'(inst), 64'hCAFE_F00D);
    resp_valid = 1'b0;
    tick;
    chk("t5_cnt4", fetch_cnt, 64'd4);
    tick;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick;
    redirect_valid = 1'b0; resp_valid = 1'b1; resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    resp_valid = 1'b0;
    chk("t3_iv_discard", 64'(inst_valid), 64'd0);
    chk("t3_req_valid", 64'(req_valid), 64'd1);
    chk("t3_addr", req_addr, 64'h8000_0100);
    chk("t3_cnt", fetch_cnt, 64'd4);
    tick;
    resp_valid = 1'b1; resp_data = 64'h5555_6666_7777_8888;
    tick;
    chk("t3_pc", inst_pc, 64'h8000_0100);
    chk("t3_inst", 64'(inst), 64'h7777_8888);
    resp_valid = 1'b0; inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t4_hold_iv", 64'(inst_valid), 64'd1);
      chk("t4_hold_inst", 64'(inst), 64'h7777_8888);
      chk("t4_hold_pc", inst_pc, 64'h8000_0100);
    end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0203;
    tick;
    redirect_valid = 1'b0;
    chk("t4_iv_drop", 64'(inst_valid), 64'd0);
    chk("t4_cnt", fetch_cnt, 64'd4);
    chk("t4_addr", req_addr, 64'h8000_0200);
    tick;
    resp_valid = 1'b1; resp_data = 64'h9999_AAAA_BBBB_CCCC;
    tick;
    chk("t4_pc", inst_pc, 64'h8000_0200);
    chk("t4_inst", 64'(inst), 64'hBBBB_CCCC);
    resp_valid = 1'b0; inst_ready = 1'b1;
    tick;
    chk("t4_cnt5", fetch_cnt, 64'd5);
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    tick;
    redirect_valid = 1'b0;
    chk("rq_addr_stable", req_addr, 64'h8000_0200);
    req_ready = 1'b1;
    tick;
    resp_valid = 1'b1; resp_data = 64'h0BAD_0BAD_0BAD_0BAD;
    tick;
    resp_valid = 1'b0;
    chk("rq_iv_discard", 64'(inst_valid), 64'd0);
    chk("rq_addr", req_addr, 64'h8000_0300);
    tick;
    resp_valid = 1'b1; resp_data = 64'h1234_5678_0000_0001;
    tick;
    chk("rq_inst", 64'(inst), 64'h0000_0001);
    chk("rq_pc", inst_pc, 64'h8000_0300);
    resp_valid = 1'b0;
    tick;
    chk("rq_cnt", fetch_cnt, 64'd6);
    tick;
    rst = 1'b1;
    #1;
    chk("t6_async_addr", req_addr, 64'h8000_0000);
    chk("t6_async_cnt", fetch_cnt, 64'd0);
    tick;
    rst = 1'b0; req_ready = 1'b0; resp_valid = 1'b1; resp_data = 64'hEEEE_EEEE_EEEE_EEEE;
    tick;
    resp_valid = 1'b0;
    chk("t6_stale_iv", 64'(inst_valid), 64'd0);
    chk("t6_req_valid", 64'(req_valid), 64'd1);
    chk("t6_addr", req_addr, 64'h8000_0000);
    req_ready = 1'b1;
    tick;
    resp_valid = 1'b1; resp_data = 64'h0000_0000_0000_0013;
    tick;
    resp_valid = 1'b0;
    chk("t6_inst", 64'(inst), 64'h0000_0013);
    chk("t6_pc", inst_pc, 64'h8000_0000);
    chk("t6_cnt0", fetch_cnt, 64'd0);
    tick;
    chk("t6_cnt1", fetch_cnt, 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
